// File: rtl/vga_pattern_pkg.sv
// Shared mode encoding and bar-colour helper for the VGA pattern generator.
package vga_pattern_pkg;

   localparam int NUM_MODES = 6;
   localparam int MODE_W    = 3;

   typedef enum logic [MODE_W-1:0] {
      SOLID    = 3'd0,
      VBARS    = 3'd1,
      HBARS    = 3'd2,
      CHECKER  = 3'd3,
      GRADIENT = 3'd4,
      SCROLL   = 3'd5
   } mode_e;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } bar_rgb_t;

   // Each bar index bit switches one channel fully on: bit2=R, bit1=G, bit0=B.
   function automatic bar_rgb_t bar_rgb(input logic [2:0] idx);
      bar_rgb_t c;
      c.r = idx[2];
      c.g = idx[1];
      c.b = idx[0];
      return c;
   endfunction

endpackage

// File: rtl/vga_pattern_gen_edge_stepper.sv
// Rising-edge up/down stepper over 0..N-1 with wrap-around; simultaneous
// up and down edges cancel. Usable for any next/prev menu selector.
module edge_stepper #(
   parameter int N = 6,
   parameter int W = 3
) (
   input  logic         clk_sys,
   input  logic         rst,
   input  logic         up,
   input  logic         dn,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic up_q;
   logic dn_q;
   logic up_rise;
   logic dn_rise;

   assign up_rise = up & ~up_q;
   assign dn_rise = dn & ~dn_q;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         up_q  <= 1'b0;
         dn_q  <= 1'b0;
         count <= '0;
      end else begin
         up_q <= up;
         dn_q <= dn;
         if (up_rise && !dn_rise) begin
            count <= (count == LAST) ? '0 : count + W'(1);
         end else if (dn_rise && !up_rise) begin
            count <= (count == '0) ? LAST : count - W'(1);
         end
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source between the VGA timing generator and the RGB pins.
// Mode changes are staged in a pending selector and applied at vblank entry.
module vga_pattern_gen
   import vga_pattern_pkg::*;
#(
   parameter int COLOR_BITS   = 4,
   parameter int COORD_BITS   = 11,
   parameter int V_ACTIVE     = 480,
   parameter int BAR_SHIFT    = 6,
   parameter int CHK_SHIFT    = 5,
   parameter int GRAD_SHIFT   = 5,
   parameter int SCROLL_SHIFT = 2
) (
   input  logic                  CLK50MHZ,
   input  logic                  RST,
   input  logic                  next,
   input  logic                  prev,
   input  logic [COORD_BITS-1:0] x,
   input  logic [COORD_BITS-1:0] y,
   input  logic                  displaying,
   output logic [COLOR_BITS-1:0] VGA_R,
   output logic [COLOR_BITS-1:0] VGA_G,
   output logic [COLOR_BITS-1:0] VGA_B,
   output logic [MODE_W-1:0]     mode,
   output logic [7:0]            frame_cnt
);

   localparam logic [COLOR_BITS-1:0] CMAX   = '1;
   localparam logic [COORD_BITS-1:0] V_LINE = COORD_BITS'(V_ACTIVE);
   localparam logic [COORD_BITS-1:0] G_CAP  = COORD_BITS'(CMAX);

   logic [MODE_W-1:0]     pending;
   mode_e                 mode_q;
   logic [7:0]            frame_q;
   logic [COORD_BITS-1:0] y_q;
   logic                  ft;

   logic [COORD_BITS-1:0] x_grad;
   logic [COLOR_BITS-1:0] grad;
   logic [2:0]            bi;
   bar_rgb_t              bar;
   logic [COLOR_BITS-1:0] r_d;
   logic [COLOR_BITS-1:0] g_d;
   logic [COLOR_BITS-1:0] b_d;

   edge_stepper #(
      .N (NUM_MODES),
      .W (MODE_W)
   ) u_mode_step (
      .clk_sys (CLK50MHZ),
      .rst     (RST),
      .up      (next),
      .dn      (prev),
      .count   (pending)
   );

   // One pulse per frame: first cycle of the first non-visible line.
   assign ft = (y == V_LINE) && (y_q != V_LINE);

   assign x_grad = x >> GRAD_SHIFT;

   always_comb begin
      bi = x[BAR_SHIFT +: 3];
      if (mode_q == HBARS) begin
         bi = y[BAR_SHIFT +: 3];
      end else if (mode_q == SCROLL) begin
         bi = x[BAR_SHIFT +: 3] + frame_q[SCROLL_SHIFT +: 3];
      end
      bar  = bar_rgb(bi);
      grad = (x_grad > G_CAP) ? CMAX : x_grad[COLOR_BITS-1:0];

      r_d = '0;
      g_d = '0;
      b_d = '0;
      case (mode_q)
         SOLID: begin
            r_d = CMAX;
            b_d = CMAX;
         end
         VBARS, HBARS, SCROLL: begin
            r_d = {COLOR_BITS{bar.r}};
            g_d = {COLOR_BITS{bar.g}};
            b_d = {COLOR_BITS{bar.b}};
         end
         CHECKER: begin
            if (x[CHK_SHIFT] ^ y[CHK_SHIFT]) begin
               r_d = CMAX;
               g_d = CMAX;
               b_d = CMAX;
            end
         end
         GRADIENT: begin
            r_d = grad;
            g_d = grad;
            b_d = grad;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         mode_q  <= SOLID;
         frame_q <= '0;
         y_q     <= '0;
         VGA_R   <= '0;
         VGA_G   <= '0;
         VGA_B   <= '0;
      end else begin
         y_q <= y;
         if (ft) begin
            mode_q  <= mode_e'(pending);
            frame_q <= frame_q + 8'd1;
         end
         VGA_R <= displaying ? r_d : '0;
         VGA_G <= displaying ? g_d : '0;
         VGA_B <= displaying ? b_d : '0;
      end
   end

   assign mode      = mode_q;
   assign frame_cnt = frame_q;

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised successor to the fixed-colour VGA colour controller.
- Generates six selectable test patterns, including an animated scrolling pattern, from the timing generator's x/y/displaying.
- next/prev step through the patterns. A mode change takes effect only at vertical-blank entry, so a frame never tears.
- Sits between the VGA timing generator and the VGA_R/G/B pins. RGB is registered, with 1-cycle latency.

Parameters:
COLOR_BITS, 4, bits per colour channel
COORD_BITS, 11, width of x/y
V_ACTIVE, 480, first non-visible line; y==V_ACTIVE marks vblank entry
BAR_SHIFT, 6, log2 of bar width/height in pixels (64 px)
CHK_SHIFT, 5, log2 of checker square size (32 px)
GRAD_SHIFT, 5, x right-shift for the gradient level
SCROLL_SHIFT, 2, frames per one-bar scroll step = 2^SCROLL_SHIFT

Ports:
CLK50MHZ  in  1  system clock, 50 MHz
RST  in  1  synchronous, active-high reset
next  in  1  step mode forward (level; internally rising-edge detected)
prev  in  1  step mode backward (level; internally rising-edge detected)
x  in  COORD_BITS  current pixel column
y  in  COORD_BITS  current pixel line
displaying  in  1  active video region
VGA_R  out  COLOR_BITS  red
VGA_G  out  COLOR_BITS  green
VGA_B  out  COLOR_BITS  blue
mode  out  3  currently applied pattern, 0..5
frame_cnt  out  8  frame counter, wraps at 255

Behaviour:
- Reset: synchronous, active-high on RST, one clock domain CLK50MHZ. Applies to all of the following:
  - mode=0, pending=0, frame_cnt=0, VGA_R/G/B=0.
  - next/prev edge registers=0, y_q=0.
  - Reset mid-frame takes effect on the next edge; pending presses are lost.
- Edge detect: nx = next & ~next_q; pv = prev & ~prev_q.
  - nx only: pending = (pending==5) ? 0 : pending+1.
  - pv only: pending = (pending==0) ? 5 : pending-1.
  - nx and pv in the same cycle: no change.
  - Held input: counts exactly once.
- Frame tick: ft = (y==V_ACTIVE) & (y_q!=V_ACTIVE), with y_q = y registered each cycle. Exactly one ft pulse per frame.
- On ft:
  - mode <= pending.
  - frame_cnt <= frame_cnt+1, modulo 256.
  - A press in the same cycle as ft updates pending. It is applied at the next ft.
- Multiple presses within one frame accumulate in pending; only the net result is applied.
- Bar index:
  - bi = (x>>BAR_SHIFT)[2:0] for VBARS/SCROLL.
  - bi = (y>>BAR_SHIFT)[2:0] for HBARS.
  - SCROLL adds (frame_cnt>>SCROLL_SHIFT)[2:0], modulo 8.
- Bar colour: R = bi[2] ? max : 0; G = bi[1] ? max : 0; B = bi[0] ? max : 0. max = 2^COLOR_BITS-1.
- Patterns, per mode:
  - 0 SOLID: R=max, G=0, B=max (magenta, legacy default).
  - 1 VBARS: bar colour by x.
  - 2 HBARS: bar colour by y.
  - 3 CHECKER: x[CHK_SHIFT]^y[CHK_SHIFT] ? white (all max) : black.
  - 4 GRADIENT: g = min(x>>GRAD_SHIFT, max) on all three channels. Saturates; never wraps.
  - 5 SCROLL: VBARS plus scroll offset.
- Output: VGA_* registered from the cycle-N inputs (x, y, displaying, mode) and appear at cycle N+1. If displaying=0 at N, VGA_* = 0 at N+1 regardless of mode.
- mode output reflects the applied mode, not pending.
- x/y beyond the visible area are never shown, because displaying gates the output.

Decomposition:
- Package vga_pattern_pkg:
  - Mode enum: SOLID=0, VBARS=1, HBARS=2, CHECKER=3, GRADIENT=4, SCROLL=5.
  - NUM_MODES=6, MODE_W=3.
  - Function bar_rgb(idx) returning the three channels.
- One natural sub-module, edge_stepper: edge detect plus wrap-around up/down counter over 0..NUM_MODES-1 with simultaneous-cancel. Reusable for other next/prev menus.
- Pattern mux and output register stay in the top level.

Test Plan:
- RST high for 2 clks, then idle → mode=0, frame_cnt=0, VGA_*=0. With displaying=1 next cycle → R=F, G=0, B=F.
- Pulse next 3 times mid-frame (y=100) → mode stays 0 until y goes 479→480, then mode=3. At x=32, y=0 output is white; at x=0, y=0 output is black.
- prev pulse at mode=0, then one ft → mode=5. next and prev high in the same cycle → pending unchanged.
- Mode 4 with x=0, 100, 480, 639 → levels 0, 3, F (saturated), F.
- Mode 5 for 4 frames (SCROLL_SHIFT=2) at x=0 → bi goes from 0 (black) to 1 (B=F only) exactly at the 4th ft. frame_cnt wraps 255→0.
- Assert RST while mode=2 with pending=4 in the middle of a line → next clock gives mode=0, pending=0, VGA_*=0, with no spurious mode change at the following ft.
